// File: rtl/heap_memory_if.sv
// Request/response bus between the program core (master) and the heap memory engine (slave).
interface heap_memory_if #(
    parameter int unsigned ARRAY_BITS = 2,
    parameter int unsigned INDEX_BITS = 2,
    parameter int unsigned WIDTH      = 12
);
    logic                  request;
    logic [7:0]            action;
    logic [ARRAY_BITS-1:0] array;
    logic [INDEX_BITS-1:0] index;
    logic [WIDTH-1:0]      in;
    logic                  ready;
    logic                  done;
    logic [WIDTH-1:0]      out;
    logic [31:0]           error;

    modport master (
        output request, action, array, index, in,
        input  ready, done, out, error
    );

    modport slave (
        input  request, action, array, index, in,
        output ready, done, out, error
    );
endinterface

// File: rtl/heap_memory.sv
// Heap engine: allocate/free/read/write/push/pop/size on a fixed pool of fixed-capacity arrays,
// one request at a time through an IDLE -> EXEC -> RESP sequence.
module heap_memory #(
    parameter int unsigned ARRAYS     = 4,
    parameter int unsigned SIZE       = 4,
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned ARRAY_BITS = 2,
    parameter int unsigned INDEX_BITS = 2
) (
    input logic          clock,
    input logic          reset,
    heap_memory_if.slave bus
);
    localparam int unsigned SIZE_BITS = $clog2(SIZE + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [7:0] ACT_NOP   = 8'd0;
    localparam logic [7:0] ACT_ALLOC = 8'd1;
    localparam logic [7:0] ACT_FREE  = 8'd2;
    localparam logic [7:0] ACT_READ  = 8'd3;
    localparam logic [7:0] ACT_WRITE = 8'd4;
    localparam logic [7:0] ACT_SIZE  = 8'd5;
    localparam logic [7:0] ACT_PUSH  = 8'd6;
    localparam logic [7:0] ACT_POP   = 8'd7;

    logic [1:0]            state;
    logic [1:0]            nextState;
    logic                  readyReg;
    logic                  doneReg;
    logic [WIDTH-1:0]      outReg;
    logic [31:0]           errorReg;

    logic [7:0]            latchAction;
    logic [ARRAY_BITS-1:0] latchArray;
    logic [INDEX_BITS-1:0] latchIndex;
    logic [WIDTH-1:0]      latchIn;

    logic [ARRAYS-1:0]     allocated;
    logic [SIZE_BITS-1:0]  sizes [ARRAYS];
    logic [WIDTH-1:0]      elements [ARRAYS][SIZE];

    logic                  arrayOk;
    logic                  indexOk;
    logic                  curAlloc;
    logic [SIZE_BITS-1:0]  curSize;
    logic                  freeFound;
    logic [ARRAY_BITS-1:0] freeArray;

    logic [WIDTH-1:0]      execOut;
    logic [31:0]           execError;
    logic [ARRAY_BITS-1:0] target;
    logic                  allocWe;
    logic                  allocValue;
    logic                  sizeWe;
    logic [SIZE_BITS-1:0]  sizeValue;
    logic                  memWe;
    logic [INDEX_BITS-1:0] memIndex;
    logic [WIDTH-1:0]      memData;

    assign bus.ready = readyReg;
    assign bus.done  = doneReg;
    assign bus.out   = outReg;
    assign bus.error = errorReg;

    // State register plus registered handshake outputs and per-array bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            readyReg  <= 1'b1;
            doneReg   <= 1'b0;
            outReg    <= '0;
            errorReg  <= '0;
            allocated <= '0;
            for (int i = 0; i < int'(ARRAYS); i++) begin
                sizes[i] <= '0;
            end
        end else begin
            state    <= nextState;
            readyReg <= (nextState == IDLE);
            doneReg  <= (nextState == RESP);
            if (state == EXEC) begin
                outReg   <= execOut;
                errorReg <= execError;
                if (allocWe) begin
                    allocated[target] <= allocValue;
                end
                if (sizeWe) begin
                    sizes[target] <= sizeValue;
                end
            end
        end
    end

    // Request fields are captured only in the accept cycle.
    always_ff @(posedge clock) begin
        if (state == IDLE && bus.request) begin
            latchAction <= bus.action;
            latchArray  <= bus.array;
            latchIndex  <= bus.index;
            latchIn     <= bus.in;
        end
    end

    // Element storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (!reset && state == EXEC && memWe) begin
            elements[latchArray][memIndex] <= memData;
        end
    end

    // Lowest-numbered free array for ALLOC.
    always_comb begin
        freeFound = 1'b0;
        freeArray = '0;
        for (int i = int'(ARRAYS) - 1; i >= 0; i--) begin
            if (!allocated[i]) begin
                freeFound = 1'b1;
                freeArray = ARRAY_BITS'(i);
            end
        end
    end

    assign arrayOk  = 32'(latchArray) < ARRAYS;
    assign indexOk  = 32'(latchIndex) < SIZE;
    assign curAlloc = arrayOk && allocated[latchArray];
    assign curSize  = sizes[latchArray];

    // Next-state and operation decode; errors leave every update disabled and out at zero.
    always_comb begin
        nextState  = state;
        execOut    = '0;
        execError  = '0;
        target     = latchArray;
        allocWe    = 1'b0;
        allocValue = 1'b0;
        sizeWe     = 1'b0;
        sizeValue  = '0;
        memWe      = 1'b0;
        memIndex   = latchIndex;
        memData    = latchIn;

        case (state)
            IDLE:    if (bus.request) nextState = EXEC;
            EXEC:    nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase

        if (latchAction > ACT_POP) begin
            execError = 32'd6;
        end else if (latchAction >= ACT_FREE && !curAlloc) begin
            execError = 32'd2;
        end else begin
            case (latchAction)
                ACT_NOP: ;
                ACT_ALLOC: begin
                    if (!freeFound) begin
                        execError = 32'd1;
                    end else begin
                        target     = freeArray;
                        allocWe    = 1'b1;
                        allocValue = 1'b1;
                        sizeWe     = 1'b1;
                        execOut    = WIDTH'(freeArray);
                    end
                end
                ACT_FREE: begin
                    allocWe = 1'b1;
                    sizeWe  = 1'b1;
                end
                ACT_READ: begin
                    if (!indexOk || SIZE_BITS'(latchIndex) >= curSize) begin
                        execError = 32'd3;
                    end else begin
                        execOut = elements[latchArray][latchIndex];
                    end
                end
                ACT_WRITE: begin
                    if (!indexOk) begin
                        execError = 32'd3;
                    end else begin
                        memWe   = 1'b1;
                        execOut = latchIn;
                        if (SIZE_BITS'(latchIndex) >= curSize) begin
                            sizeWe    = 1'b1;
                            sizeValue = SIZE_BITS'(latchIndex) + SIZE_BITS'(1);
                        end
                    end
                end
                ACT_SIZE: execOut = WIDTH'(curSize);
                ACT_PUSH: begin
                    if (curSize == SIZE_BITS'(SIZE)) begin
                        execError = 32'd4;
                    end else begin
                        memWe     = 1'b1;
                        memIndex  = INDEX_BITS'(curSize);
                        sizeWe    = 1'b1;
                        sizeValue = curSize + SIZE_BITS'(1);
                        execOut   = WIDTH'(curSize);
                    end
                end
                ACT_POP: begin
                    if (curSize == '0) begin
                        execError = 32'd5;
                    end else begin
                        sizeWe    = 1'b1;
                        sizeValue = curSize - SIZE_BITS'(1);
                        execOut   = elements[latchArray][INDEX_BITS'(curSize - SIZE_BITS'(1))];
                    end
                end
                default: execError = 32'd6;
            endcase
        end
    end
endmodule

// File: tb/tb_heap_memory.sv
// Directed bench for heap_memory: expected responses queued at issue time, checked when done pulses.
module tb_heap_memory;
    logic clock;
    logic reset;

    heap_memory_if #(.ARRAY_BITS(2), .INDEX_BITS(2), .WIDTH(12)) bus();

    heap_memory #(
        .ARRAYS(4), .SIZE(4), .WIDTH(12), .ARRAY_BITS(2), .INDEX_BITS(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        string       tag;
        logic [11:0] out;
        logic [31:0] err;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic waitReady(input string tag);
        for (int i = 0; i < 20 && bus.ready !== 1'b1; i++) stepCycle();
        check({tag, "_ready_wait"}, 32'(bus.ready), 32'd1);
    endtask

    // Issue one request, verify the two-cycle busy window and the single done pulse.
    task automatic op(input string tag, input logic [7:0] act, input logic [1:0] arr,
                      input logic [1:0] idx, input logic [11:0] din,
                      input logic [11:0] expOut, input logic [31:0] expErr);
        exp_t e;
        exp_t got;
        waitReady(tag);
        bus.request = 1'b1;
        bus.action  = act;
        bus.array   = arr;
        bus.index   = idx;
        bus.in      = din;
        e.tag = tag;
        e.out = expOut;
        e.err = expErr;
        sbq.push_back(e);
        stepCycle();
        bus.request = 1'b0;
        bus.action  = 8'($urandom);
        bus.array   = 2'($urandom);
        bus.index   = 2'($urandom);
        bus.in      = 12'($urandom);
        check({tag, "_busy"}, {30'd0, bus.ready, bus.done}, 32'd0);
        stepCycle();
        check({tag, "_done"}, {30'd0, bus.ready, bus.done}, 32'd1);
        if (sbq.size() > 0) begin
            got = sbq.pop_front();
            check({got.tag, "_out"}, 32'(bus.out), 32'(got.out));
            check({got.tag, "_err"}, bus.error, got.err);
        end
        stepCycle();
        check({tag, "_idle"}, {30'd0, bus.ready, bus.done}, 32'd2);
    endtask

    initial begin
        int doneCount;
        reset       = 1'b1;
        bus.request = 1'b0;
        bus.action  = '0;
        bus.array   = '0;
        bus.index   = '0;
        bus.in      = '0;
        stepCycle();
        stepCycle();
        reset = 1'b0;
        check("reset_ready", 32'(bus.ready), 32'd1);
        check("reset_done",  32'(bus.done),  32'd0);
        check("reset_out",   32'(bus.out),   32'd0);
        check("reset_error", bus.error,      32'd0);

        op("nop",    8'd0, 2'd0, 2'd0, 12'h123, 12'h000, 32'd0);
        op("alloc0", 8'd1, 2'd3, 2'd0, 12'h000, 12'h000, 32'd0);
        op("alloc1", 8'd1, 2'd0, 2'd0, 12'h000, 12'h001, 32'd0);
        op("alloc2", 8'd1, 2'd0, 2'd0, 12'h000, 12'h002, 32'd0);
        op("alloc3", 8'd1, 2'd0, 2'd0, 12'h000, 12'h003, 32'd0);
        op("alloc4", 8'd1, 2'd0, 2'd0, 12'h000, 12'h000, 32'd1);

        op("push_a",  8'd6, 2'd0, 2'd0, 12'h00A, 12'h000, 32'd0);
        op("push_b",  8'd6, 2'd0, 2'd0, 12'h00B, 12'h001, 32'd0);
        op("size0",   8'd5, 2'd0, 2'd0, 12'h000, 12'h002, 32'd0);
        op("pop_b",   8'd7, 2'd0, 2'd0, 12'h000, 12'h00B, 32'd0);
        op("pop_a",   8'd7, 2'd0, 2'd0, 12'h000, 12'h00A, 32'd0);
        op("pop_emp", 8'd7, 2'd0, 2'd0, 12'h000, 12'h000, 32'd5);
        op("size0b",  8'd5, 2'd0, 2'd0, 12'h000, 12'h000, 32'd0);

        op("write13",  8'd4, 2'd1, 2'd3, 12'hFFF, 12'hFFF, 32'd0);
        op("size1",    8'd5, 2'd1, 2'd0, 12'h000, 12'h004, 32'd0);
        op("read13",   8'd3, 2'd1, 2'd3, 12'h000, 12'hFFF, 32'd0);
        op("write10",  8'd4, 2'd1, 2'd0, 12'h5A5, 12'h5A5, 32'd0);
        op("read10",   8'd3, 2'd1, 2'd0, 12'h000, 12'h5A5, 32'd0);
        op("push_ful", 8'd6, 2'd1, 2'd0, 12'h111, 12'h000, 32'd4);
        op("read20",   8'd3, 2'd2, 2'd0, 12'h000, 12'h000, 32'd3);

        op("free2",    8'd2, 2'd2, 2'd0, 12'h000, 12'h000, 32'd0);
        op("read_fr",  8'd3, 2'd2, 2'd0, 12'h000, 12'h000, 32'd2);
        op("realloc",  8'd1, 2'd0, 2'd0, 12'h000, 12'h002, 32'd0);
        op("bad_act",  8'd8, 2'd1, 2'd0, 12'h000, 12'h000, 32'd6);
        op("size1_ok", 8'd5, 2'd1, 2'd0, 12'h000, 12'h004, 32'd0);

        // Requests in the busy cycles must be dropped, not queued.
        waitReady("busy");
        doneCount   = 0;
        bus.request = 1'b1;
        bus.action  = 8'd5;
        bus.array   = 2'd1;
        stepCycle();
        bus.action  = 8'd1;
        stepCycle();
        doneCount += int'(bus.done);
        check("busy_out", 32'(bus.out), 32'd4);
        stepCycle();
        bus.request = 1'b0;
        for (int i = 0; i < 4; i++) begin
            doneCount += int'(bus.done);
            stepCycle();
        end
        check("busy_done_count", 32'(doneCount), 32'd1);
        check("busy_no_alloc_err", bus.error, 32'd0);

        // Reset during EXEC of a PUSH: no done, ready next cycle, pool cleared.
        waitReady("rst_mid");
        bus.request = 1'b1;
        bus.action  = 8'd6;
        bus.array   = 2'd0;
        bus.in      = 12'h077;
        stepCycle();
        bus.request = 1'b0;
        reset       = 1'b1;
        stepCycle();
        reset = 1'b0;
        check("rst_mid_ready", {30'd0, bus.ready, bus.done}, 32'd2);
        doneCount = 0;
        for (int i = 0; i < 3; i++) begin
            doneCount += int'(bus.done);
            stepCycle();
        end
        check("rst_mid_no_done", 32'(doneCount), 32'd0);
        op("size_after_rst0", 8'd5, 2'd0, 2'd0, 12'h000, 12'h000, 32'd2);
        op("size_after_rst3", 8'd5, 2'd3, 2'd0, 12'h000, 12'h000, 32'd2);
        op("alloc_after_rst", 8'd1, 2'd0, 2'd0, 12'h000, 12'h000, 32'd0);

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/heap_memory.md
Name: heap_memory

Overview:
- Array-memory engine that services the heap requests issued by the generated-program core: allocate, free, read, write, push, pop and size on a fixed pool of fixed-capacity arrays.
- Sits directly downstream of the program core. The core presents action/array/index/in, then waits for done and collects out and error.
- Single clock domain; one request in flight at a time.

Parameters:
- ARRAYS, 4: number of arrays in the pool.
- SIZE, 4: capacity of each array, in elements.
- WIDTH, 12: element width, in bits.
- ARRAY_BITS, 2: width of the array number; equals clog2(ARRAYS).
- INDEX_BITS, 2: width of an index; equals clog2(SIZE).

Ports:
- clock, input, 1: driving clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- request, input, 1: request strobe; accepted only when ready=1.
- action, input, 8: operation code (see Behaviour).
- array, input, ARRAY_BITS: target array number.
- index, input, INDEX_BITS: element index for read/write.
- in, input, WIDTH: write/push data.
- ready, output, 1: high when a new request may be accepted.
- done, output, 1: one-cycle pulse; out and error are valid in this cycle.
- out, output, WIDTH: result data.
- error, output, 32: 0 means success, otherwise an error code.

Behaviour:
- Reset (synchronous, active-high, clock is the only clock):
  - Outputs: ready=1, done=0, out=0, error=0.
  - All allocation bits cleared; all sizes set to 0.
  - Element storage is not cleared.
- FSM states and transitions:
  - IDLE (ready=1): request=1 latches action/array/index/in, then goes to EXEC.
  - EXEC (ready=0): performs the operation, registers out/error and updates state, then goes to RESP.
  - RESP (ready=0, done=1): goes to IDLE.
- Latency: request accepted in cycle N; done=1 in cycle N+2; ready=1 again in cycle N+3.
- Handshake rules:
  - request while ready=0 is ignored; it is not queued.
  - Inputs are sampled only in the accept cycle.
  - out and error hold their values until the next EXEC.
- Each array keeps an allocated bit, a size counter of clog2(SIZE+1) bits, and SIZE elements.
- Action codes:
  - 0 NOP: out=0, error=0.
  - 1 ALLOC: take the lowest-numbered free array, mark it allocated, set its size to 0; out = array number zero-extended.
  - 2 FREE: clear the allocated bit, set size to 0; out=0.
  - 3 READ: requires index<size; out=element[index].
  - 4 WRITE: element[index]=in; if index>=size, size becomes index+1; out=in.
  - 5 SIZE: out = size zero-extended.
  - 6 PUSH: requires size<SIZE; element[size]=in, size increments; out = old size.
  - 7 POP: requires size>0; size decrements; out = element[new size].
- Error codes and precedence (first match wins):
  - 6: action>7.
  - 2: array not allocated, for actions 2-7.
  - 1: ALLOC with no free array.
  - 3: READ with index>=size.
  - 4: PUSH with size==SIZE.
  - 5: POP with size==0.
- On any error: no state change, out=0.
- Boundary conditions:
  - WRITE at index SIZE-1 sets size to SIZE.
  - PUSH after that returns error 4.
  - FREE then ALLOC reuses the same array number when it is the lowest free one.
  - Array and index are always in range by width only when ARRAYS and SIZE are powers of two. Otherwise array>=ARRAYS returns error 2 and index>=SIZE returns error 3, for WRITE as well as READ.
- Reset mid-operation: reset in EXEC or RESP returns to IDLE next cycle with no done pulse. The operation's state update is discarded, because allocation and size are cleared.

Test Plan:
- Reset, then four ALLOCs -> out=0,1,2,3 with error=0; fifth ALLOC -> out=0, error=1; done in cycle N+2 each time, ready low for two cycles.
- Array 0: PUSH 12'h00A, PUSH 12'h00B -> out=0,1. SIZE -> out=2. POP -> out=12'h00B. POP -> out=12'h00A. POP -> error=5, size stays 0.
- Array 1: WRITE index 3 data 12'hFFF -> size=4. READ index 3 -> out=12'hFFF. PUSH -> error=4. READ on array 2 at index 0 (size 0) -> error=3.
- FREE array 2, then READ array 2 -> error=2. ALLOC -> out=2. Action 8 -> error=6, no state change.
- Pulse request in cycles N+1 and N+2 of a busy operation -> ignored, exactly one done. Assert reset in the EXEC cycle of a PUSH -> no done, ready=1 next cycle. SIZE on any array then returns error 2, because all arrays are freed.
